mac_acc_unit: RTL and testbench

MAC_ACC_UNIT -- requirements
Module: mac_acc_unit

---
 rtl/mac_acc_pkg.sv | 14 +
 rtl/seq_shift_mul.sv | 65 ++++++
 rtl/mac_acc_unit.sv | 101 ++++++++++
 tb/tb_mac_acc_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_acc_pkg.sv
// Shared definitions for the multiply-accumulate unit: FSM state encoding and default widths.
package mac_acc_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 2 * DEF_DW + 4;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ACC,
    DONE
  } state_e;

endpackage

// File: rtl/seq_shift_mul.sv
// Iterative signed multiplier: shift-add over |w|, one bit per cycle, sign applied to the final magnitude.
module seq_shift_mul
  import mac_acc_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   abort,
  input  logic                   start,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   w,
  output logic                   done,
  output logic signed [2*DW-1:0] product
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  logic            busy;
  logic [CW-1:0]   cnt;
  logic            neg;
  logic [2*DW-1:0] mcand;
  logic [2*DW-1:0] partial;
  logic [DW-1:0]   mplier;
  logic [DW-1:0]   mag_a;
  logic [DW-1:0]   mag_w;

  // Unsigned magnitudes: -2^(DW-1) negates to itself, which reads correctly as 2^(DW-1).
  assign mag_a = a[DW-1] ? (~a + 1'b1) : a;
  assign mag_w = w[DW-1] ? (~w + 1'b1) : w;

  // High during the cycle whose closing edge performs the last shift-add step.
  assign done = busy && (cnt == CW'(DW - 1));

  assign product = $signed(neg ? (~partial + 1'b1) : partial);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      cnt     <= '0;
      neg     <= 1'b0;
      mcand   <= '0;
      partial <= '0;
      mplier  <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      cnt     <= '0;
      neg     <= a[DW-1] ^ w[DW-1];
      mcand   <= {{DW{1'b0}}, mag_a};
      partial <= '0;
      mplier  <= mag_w;
    end else if (busy) begin
      if (mplier[0]) partial <= partial + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_acc_unit.sv
// Multiply-accumulate unit: sequential products summed into a saturating or wrapping accumulator,
// with a valid/ready handshake on both the operand and the result side.
module mac_acc_unit
  import mac_acc_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int AW  = 2 * DW + 4,
  parameter int SAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] w,
  input  logic                 last,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [AW-1:0] acc_out,
  output logic                 ovf
);

  state_e                  state, state_nx;
  logic                    last_q;
  logic signed [AW-1:0]    acc;
  logic                    ovf_q;
  logic                    start;
  logic                    mul_done;
  logic signed [2*DW-1:0]  product;
  logic [AW:0]             sum;
  logic                    sum_ovf;
  logic [AW-1:0]           sum_fixed;

  assign start = in_valid && in_ready && !clear;

  seq_shift_mul #(.DW(DW)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .abort   (clear),
    .start   (start),
    .a       (a),
    .w       (w),
    .done    (mul_done),
    .product (product)
  );

  // One guard bit: overflow shows as disagreement between the two top bits of the widened sum.
  assign sum     = {acc[AW-1], acc} + {{(AW + 1 - 2*DW){product[2*DW-1]}}, product};
  assign sum_ovf = sum[AW] ^ sum[AW-1];

  always_comb begin
    sum_fixed = sum[AW-1:0];
    if ((SAT != 0) && sum_ovf)
      sum_fixed = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = MUL;
      end
      MUL:  if (mul_done) state_nx = ACC;
      ACC:  state_nx = last_q ? DONE : IDLE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_q <= 1'b0;
      acc    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) last_q <= last;
      if (clear || (state == DONE && out_ready)) begin
        acc   <= '0;
        ovf_q <= 1'b0;
      end else if (state == ACC) begin
        acc   <= $signed(sum_fixed);
        ovf_q <= ovf_q | sum_ovf;
      end
    end
  end

  assign acc_out = acc;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mac_acc_unit.sv
// Directed and randomized bench for mac_acc_unit: a saturating and a wrapping instance share stimulus
// and are compared against an arithmetic model of the dot product.
module tb_mac_acc_unit;

  localparam int DW = 8;
  localparam int AW = 2 * DW + 4;
  localparam longint MAXV = (64'sd1 <<< (AW - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (AW - 1));
  localparam longint MODV = 64'sd1 <<< AW;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 last = 1'b0;
  logic                 clear = 1'b0;
  logic                 out_ready = 1'b0;
  logic signed [DW-1:0] a = '0;
  logic signed [DW-1:0] w = '0;

  logic                 in_ready_s, out_valid_s, ovf_s;
  logic                 in_ready_w, out_valid_w, ovf_w;
  logic signed [AW-1:0] acc_s, acc_w;

  int n_vec = 0;
  int n_err = 0;

  longint ms, mw;
  logic   mov_s, mov_w;

  mac_acc_unit #(.DW(DW), .AW(AW), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .w(w), .last(last), .clear(clear), .out_valid(out_valid_s),
    .out_ready(out_ready), .acc_out(acc_s), .ovf(ovf_s)
  );

  mac_acc_unit #(.DW(DW), .AW(AW), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .w(w), .last(last), .clear(clear), .out_valid(out_valid_w),
    .out_ready(out_ready), .acc_out(acc_w), .ovf(ovf_w)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_valid, input logic exp_ready);
    check({tag, ".acc_sat"},   acc_s,       ms);
    check({tag, ".acc_wrap"},  acc_w,       mw);
    check({tag, ".ovf_sat"},   ovf_s,       mov_s);
    check({tag, ".ovf_wrap"},  ovf_w,       mov_w);
    check({tag, ".valid_sat"}, out_valid_s, exp_valid);
    check({tag, ".valid_wrap"},out_valid_w, exp_valid);
    check({tag, ".ready_sat"}, in_ready_s,  exp_ready);
    check({tag, ".ready_wrap"},in_ready_w,  exp_ready);
  endtask

  function automatic void model_reset();
    ms = 0; mw = 0; mov_s = 1'b0; mov_w = 1'b0;
  endfunction

  // Dot product in plain integers, then clamped or folded back into AW-bit signed range.
  function automatic void model_add(input longint p);
    ms = ms + p;
    if (ms > MAXV) begin ms = MAXV; mov_s = 1'b1; end
    else if (ms < MINV) begin ms = MINV; mov_s = 1'b1; end
    mw = mw + p;
    if (mw > MAXV) begin mw = mw - MODV; mov_w = 1'b1; end
    else if (mw < MINV) begin mw = mw + MODV; mov_w = 1'b1; end
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_term(input logic signed [DW-1:0] ta, input logic signed [DW-1:0] tw,
                           input logic tl, input logic junk);
    int guard = 0;
    while (!(in_ready_s && in_ready_w) && guard < 50) begin
      step();
      guard++;
    end
    check("send.ready_wait", in_ready_s & in_ready_w, 1);
    a = ta; w = tw; last = tl; in_valid = 1'b1;
    step();
    if (junk) begin
      a = ~ta; w = tw + 8'sd3; last = ~tl;
    end else begin
      in_valid = 1'b0;
    end
    check_all("mul", 1'b0, 1'b0);
    repeat (DW) step();
    check_all("acc_pending", 1'b0, 1'b0);
    in_valid = 1'b0;
    model_add(longint'(ta) * longint'(tw));
    step();
    check_all("term", tl, !tl);
  endtask

  task automatic release_result();
    check_all("done_hold", 1'b1, 1'b0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    model_reset();
    check_all("released", 1'b0, 1'b1);
  endtask

  initial begin
    logic signed [DW-1:0] ra, rw;
    int n;

    model_reset();
    rst_n = 1'b0;
    repeat (2) step();
    check_all("reset", 1'b0, 1'b1);
    rst_n = 1'b1;
    step();

    // Basic term and first-result latency.
    send_term(8'sd3, 8'sd5, 1'b1, 1'b0);
    release_result();

    // Most-negative operands.
    send_term(-8'sd128, -8'sd128, 1'b1, 1'b0);
    release_result();
    send_term(-8'sd128, 8'sd127, 1'b1, 1'b0);
    release_result();

    // Three-term dot product with downstream back-pressure.
    send_term(8'sd10, 8'sd10, 1'b0, 1'b0);
    send_term(-8'sd4, 8'sd6, 1'b0, 1'b0);
    send_term(8'sd7, -8'sd3, 1'b1, 1'b0);
    repeat (5) begin
      step();
      check_all("hold", 1'b1, 1'b0);
    end
    release_result();

    // Operands changing while busy must not be picked up.
    send_term(8'sd12, -8'sd9, 1'b0, 1'b1);
    send_term(-8'sd33, -8'sd2, 1'b1, 1'b1);
    release_result();

    // Random dot products.
    for (int d = 0; d < 4; d++) begin
      n = int'($urandom_range(1, 5));
      for (int i = 0; i < n; i++) begin
        ra = DW'($urandom);
        rw = DW'($urandom);
        send_term(ra, rw, (i == n - 1), 1'b0);
      end
      release_result();
    end

    // Accumulator overflow: saturation on one instance, wrap on the other.
    for (int i = 0; i < 33; i++) send_term(8'sd127, 8'sd127, (i == 32), 1'b0);
    check("ovf_long.sat_clamp", acc_s, MAXV);
    release_result();

    // Clear in the middle of a multiply discards the term and the running sum.
    send_term(8'sd5, 8'sd5, 1'b0, 1'b0);
    a = 8'sd9; w = 8'sd9; last = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_reset();
    check_all("clear_mul", 1'b0, 1'b1);
    repeat (DW + 2) step();
    check_all("clear_quiet", 1'b0, 1'b1);

    // Clear wins over a simultaneous operand offer.
    a = 8'sd7; w = 8'sd7; last = 1'b1; in_valid = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0;
    check_all("clear_vs_valid", 1'b0, 1'b1);

    // Clear while a result is waiting.
    send_term(8'sd2, 8'sd2, 1'b1, 1'b0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_reset();
    check_all("clear_done", 1'b0, 1'b1);

    // Asynchronous reset mid-multiply, with a partial sum already present.
    send_term(8'sd4, 8'sd4, 1'b0, 1'b0);
    a = 8'sd50; w = 8'sd50; last = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("rst_mid_mul", 1'b0, 1'b1);
    step();
    rst_n = 1'b1;
    repeat (DW + 3) step();
    check_all("post_rst", 1'b0, 1'b1);

    // Asynchronous reset while a result is waiting.
    send_term(8'sd20, 8'sd20, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("rst_mid_done", 1'b0, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    send_term(8'sd3, 8'sd5, 1'b1, 1'b0);
    release_result();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
